// File: rtl/ddr3_dly_pkg.sv
// Shared encodings for the DDR3 IOD delay-line controller: request ops,
// completion status codes and FSM state constants.
package ddr3_dly_pkg;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_CLIP = 2'b01;
  localparam logic [1:0] ST_OOR  = 2'b10;

  typedef logic [2:0] dly_state_t;

  localparam dly_state_t S_IDLE  = 3'd0;
  localparam dly_state_t S_SETUP = 3'd1;
  localparam dly_state_t S_MOVE  = 3'd2;
  localparam dly_state_t S_GAP   = 3'd3;
  localparam dly_state_t S_LOAD  = 3'd4;
  localparam dly_state_t S_FIN   = 3'd5;

endpackage

// File: rtl/ddr3_sync2.sv
// Two-flop synchroniser for a slow level from the IOD into the fabric clock.
module ddr3_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Double-register the asynchronous level; both stages clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/ddr3_iod_dly_ctrl.sv
// Owns one IOD lane's dynamic delay-line port: sequences LOAD/MOVE/DIRECTION
// with settling gaps, tracks the tap position and reports completion status.
module ddr3_iod_dly_ctrl
  import ddr3_dly_pkg::*;
#(
  parameter int TAP_W    = 8,
  parameter int TAP_MAX  = 127,
  parameter int TAP_INIT = 1,
  parameter int STEP_W   = 8,
  parameter int MOVE_GAP = 4
) (
  input  logic              FAB_CLK,
  input  logic              ARST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [1:0]        REQ_OP,
  input  logic [STEP_W-1:0] REQ_STEPS,
  output logic              DONE,
  output logic [1:0]        DONE_STATUS,
  output logic [TAP_W-1:0]  TAP_POS,
  output logic              DELAY_LINE_MOVE_0,
  output logic              DELAY_LINE_DIRECTION_0,
  output logic              DELAY_LINE_LOAD_0,
  input  logic              DELAY_LINE_OUT_OF_RANGE_0
);

  localparam int GAP_W = $clog2(MOVE_GAP);
  // GAP counts down from here so the last GAP cycle sees zero.
  localparam logic [GAP_W-1:0]  GAP_RELOAD = GAP_W'(MOVE_GAP - 2);
  localparam logic [GAP_W-1:0]  GAP_ONE    = GAP_W'(1);
  localparam logic [TAP_W-1:0]  TAP_MAX_V  = TAP_W'(TAP_MAX);
  localparam logic [TAP_W-1:0]  TAP_INIT_V = TAP_W'(TAP_INIT);
  localparam logic [TAP_W-1:0]  TAP_ONE    = TAP_W'(1);
  localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);

  dly_state_t        state_r;
  dly_state_t        state_nxt_s;
  logic [1:0]        status_nxt_s;
  logic [1:0]        op_r;
  logic [STEP_W-1:0] steps_r;
  logic [GAP_W-1:0]  gap_r;
  logic [TAP_W-1:0]  tap_r;
  logic [1:0]        status_r;
  logic              dir_r;
  logic              ready_r;
  logic              done_r;
  logic              move_r;
  logic              load_r;
  logic              oor_s;
  logic              accept_s;
  logic              at_limit_s;

  ddr3_sync2 u_oor_sync (
    .clk (FAB_CLK),
    .rst (ARST),
    .d   (DELAY_LINE_OUT_OF_RANGE_0),
    .q   (oor_s)
  );

  assign accept_s   = REQ_VALID & ready_r;
  assign at_limit_s = dir_r ? (tap_r == TAP_MAX_V) : (tap_r == {TAP_W{1'b0}});

  // Next-state and completion-status decode; abort outranks clip.
  always_comb begin
    state_nxt_s  = state_r;
    status_nxt_s = ST_OK;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          case (REQ_OP)
            OP_INC, OP_DEC: state_nxt_s = S_SETUP;
            OP_LOAD:        state_nxt_s = S_LOAD;
            default:        state_nxt_s = S_FIN;
          endcase
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_SETUP: begin
        if (steps_r == {STEP_W{1'b0}}) begin
          state_nxt_s = S_FIN;
        end else if (at_limit_s) begin
          state_nxt_s  = S_FIN;
          status_nxt_s = ST_CLIP;
        end else begin
          state_nxt_s = S_MOVE;
        end
      end
      S_MOVE: state_nxt_s = S_GAP;
      S_LOAD: state_nxt_s = S_GAP;
      S_GAP: begin
        if (gap_r != {GAP_W{1'b0}}) begin
          state_nxt_s = S_GAP;
        end else if ((op_r == OP_LOAD) || (steps_r == {STEP_W{1'b0}})) begin
          state_nxt_s = S_FIN;
        end else if (oor_s) begin
          state_nxt_s  = S_FIN;
          status_nxt_s = ST_OOR;
        end else if (at_limit_s) begin
          state_nxt_s  = S_FIN;
          status_nxt_s = ST_CLIP;
        end else begin
          state_nxt_s = S_MOVE;
        end
      end
      S_FIN:   state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, request latches, tap tracking and registered lane outputs.
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      state_r  <= S_IDLE;
      op_r     <= OP_NOP;
      steps_r  <= {STEP_W{1'b0}};
      gap_r    <= {GAP_W{1'b0}};
      tap_r    <= TAP_INIT_V;
      dir_r    <= 1'b0;
      ready_r  <= 1'b0;
      done_r   <= 1'b0;
      move_r   <= 1'b0;
      load_r   <= 1'b0;
      status_r <= ST_OK;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == S_IDLE);
      done_r  <= (state_nxt_s == S_FIN);
      move_r  <= (state_nxt_s == S_MOVE);
      load_r  <= (state_nxt_s == S_LOAD);
      if (state_nxt_s == S_FIN) begin
        status_r <= status_nxt_s;
      end
      if (accept_s) begin
        op_r    <= REQ_OP;
        steps_r <= REQ_STEPS;
        dir_r   <= (REQ_OP == OP_INC);
      end else if (state_r == S_MOVE) begin
        steps_r <= steps_r - STEP_ONE;
      end
      if ((state_r == S_MOVE) || (state_r == S_LOAD)) begin
        gap_r <= GAP_RELOAD;
      end else if ((state_r == S_GAP) && (gap_r != {GAP_W{1'b0}})) begin
        gap_r <= gap_r - GAP_ONE;
      end
      if (state_r == S_MOVE) begin
        tap_r <= dir_r ? (tap_r + TAP_ONE) : (tap_r - TAP_ONE);
      end else if (state_r == S_LOAD) begin
        tap_r <= TAP_INIT_V;
      end
    end
  end

  assign REQ_READY              = ready_r;
  assign DONE                   = done_r;
  assign DONE_STATUS            = status_r;
  assign TAP_POS                = tap_r;
  assign DELAY_LINE_MOVE_0      = move_r;
  assign DELAY_LINE_DIRECTION_0 = dir_r;
  assign DELAY_LINE_LOAD_0      = load_r;

endmodule

// File: tb/tb_ddr3_iod_dly_ctrl.sv
// Directed and randomized bench for ddr3_iod_dly_ctrl against a per-request
// timeline model derived from tap room, step count and gap spacing.
module tb_ddr3_iod_dly_ctrl;

  localparam int TAP_MAX  = 127;
  localparam int TAP_INIT = 1;
  localparam int G        = 4;
  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  logic       fab_clk = 1'b0;
  logic       arst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_steps;
  logic       done;
  logic [1:0] done_status;
  logic [7:0] tap_pos;
  logic       dl_move;
  logic       dl_dir;
  logic       dl_load;
  logic       dl_oor;

  int n_checks = 0;
  int n_fail   = 0;
  int model_tap;

  ddr3_iod_dly_ctrl dut (
    .FAB_CLK                   (fab_clk),
    .ARST                      (arst),
    .REQ_VALID                 (req_valid),
    .REQ_READY                 (req_ready),
    .REQ_OP                    (req_op),
    .REQ_STEPS                 (req_steps),
    .DONE                      (done),
    .DONE_STATUS               (done_status),
    .TAP_POS                   (tap_pos),
    .DELAY_LINE_MOVE_0         (dl_move),
    .DELAY_LINE_DIRECTION_0    (dl_dir),
    .DELAY_LINE_LOAD_0         (dl_load),
    .DELAY_LINE_OUT_OF_RANGE_0 (dl_oor)
  );

  always #5 fab_clk = ~fab_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge and check every cycle up to DONE+1.
  // oor_k > 0 raises OUT_OF_RANGE in the cycle after the k-th MOVE.
  task automatic run_op(input logic [1:0] op, input int steps, input int oor_k,
                        input bit hold, input string tag);
    int  n, room, done_c, exp_tap, wait_c;
    logic [1:0] exp_st;
    bit  is_mv, exp_move, exp_load, exp_done, exp_ready;
    is_mv  = (op == OP_INC) || (op == OP_DEC);
    exp_st = 2'b00;
    n      = 0;
    if (is_mv) begin
      room = (op == OP_INC) ? (TAP_MAX - model_tap) : model_tap;
      n    = (steps < room) ? steps : room;
      if (steps > room) exp_st = 2'b01;
      if (oor_k > 0 && oor_k <= n && oor_k < steps) begin
        n      = oor_k;
        exp_st = 2'b10;
      end
      done_c  = 2 + n * G;
      exp_tap = (op == OP_INC) ? model_tap + n : model_tap - n;
    end else if (op == OP_LOAD) begin
      done_c  = 1 + G;
      exp_tap = TAP_INIT;
    end else begin
      done_c  = 1;
      exp_tap = model_tap;
    end

    wait_c = 0;
    while (!req_ready && wait_c < 20) begin
      @(negedge fab_clk);
      wait_c++;
    end
    check({tag, "_ready_wait"}, req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_steps = steps[7:0];
    @(posedge fab_clk);
    for (int c = 1; c <= done_c + 1; c++) begin
      @(negedge fab_clk);
      if (c == 1 && !hold) req_valid = 1'b0;
      if (oor_k > 0 && c == 2 + (oor_k - 1) * G + 1) dl_oor = 1'b1;
      exp_move  = is_mv && c >= 2 && c < 2 + n * G && ((c - 2) % G == 0);
      exp_load  = (op == OP_LOAD) && c == 1;
      exp_done  = (c == done_c);
      exp_ready = (c == done_c + 1);
      check({tag, "_move"},  dl_move,   exp_move);
      check({tag, "_load"},  dl_load,   exp_load);
      check({tag, "_done"},  done,      exp_done);
      check({tag, "_ready"}, req_ready, exp_ready);
      if (is_mv && c <= done_c) check({tag, "_dir"}, dl_dir, (op == OP_INC));
      if (c == done_c) begin
        check({tag, "_status"}, done_status, exp_st);
        check({tag, "_tap"},    tap_pos,     exp_tap);
      end
    end
    dl_oor    = 1'b0;
    model_tap = exp_tap;
  endtask

  initial begin
    int rop, rsteps;
    arst      = 1'b1;
    req_valid = 1'b0;
    req_op    = OP_NOP;
    req_steps = 8'd0;
    dl_oor    = 1'b0;
    model_tap = TAP_INIT;
    #1;
    check("rst_tap",    tap_pos,     TAP_INIT);
    check("rst_ready",  req_ready,   0);
    check("rst_move",   dl_move,     0);
    check("rst_load",   dl_load,     0);
    check("rst_dir",    dl_dir,      0);
    check("rst_done",   done,        0);
    check("rst_status", done_status, 0);
    repeat (3) @(negedge fab_clk);
    arst = 1'b0;
    @(posedge fab_clk);
    #1;
    check("rel_ready", req_ready, 1);
    check("rel_done",  done,      0);
    @(negedge fab_clk);

    run_op(OP_INC,  5,   0, 1'b0, "inc5");
    run_op(OP_NOP,  0,   0, 1'b0, "nop");
    run_op(OP_LOAD, 0,   0, 1'b0, "load");
    run_op(OP_INC,  2,   0, 1'b0, "inc2");
    run_op(OP_DEC,  10,  0, 1'b0, "lowclip");
    run_op(OP_INC,  125, 0, 1'b0, "inc125");
    run_op(OP_INC,  200, 0, 1'b0, "highclip");
    run_op(OP_DEC,  4,   0, 1'b0, "dec4");
    run_op(OP_INC,  8,   2, 1'b0, "oor");
    run_op(OP_LOAD, 0,   0, 1'b1, "hold");
    run_op(OP_LOAD, 0,   0, 1'b0, "after_hold");
    run_op(OP_INC,  0,   0, 1'b0, "inc0");

    for (int i = 0; i < 20; i++) begin
      rop    = $urandom_range(0, 3);
      rsteps = $urandom_range(0, 40);
      run_op(rop[1:0], rsteps, 0, 1'b0, "rand");
    end

    // Async reset in the middle of a long increment.
    req_valid = 1'b1;
    req_op    = OP_INC;
    req_steps = 8'd10;
    @(posedge fab_clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge fab_clk);
      req_valid = 1'b0;
    end
    #2 arst = 1'b1;
    #1;
    check("midrst_move",  dl_move,   0);
    check("midrst_load",  dl_load,   0);
    check("midrst_done",  done,      0);
    check("midrst_ready", req_ready, 0);
    check("midrst_tap",   tap_pos,   TAP_INIT);
    @(negedge fab_clk);
    arst = 1'b0;
    @(posedge fab_clk);
    #1;
    check("midrel_ready", req_ready, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge fab_clk);
      check("midrel_done", done,    0);
      check("midrel_move", dl_move, 0);
    end
    model_tap = TAP_INIT;
    run_op(OP_INC, 3, 0, 1'b0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
